pipe_execute_ctrl: RTL and testbench

PIPE_EXECUTE_CTRL -- requirements
Module: pipe_execute_ctrl

---
 rtl/pipe_pkg.sv | 63 ++++++
 rtl/pipe_flopenrc.sv | 31 +++
 rtl/pipe_execute_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_execute_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the Execute-stage control slice: condition codes, flag indices, control bundles.
// No logic of its own; constants and types only.
// Not applicable: no flow control lives here.
package pipe_pkg;

    // Condition field values the Execute control treats specially.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flags nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside the two-bit flag-write enable.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    // Everything the Execute stage carries for one instruction.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       pc_src;
        logic [1:0] flag_write;
        logic [3:0] cond;
        logic [3:0] wa3;
    } ctrl_e_t;

    // Control handed on to the Memory stage, already gated by the condition.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic [3:0] wa3;
    } ctrl_m_t;

    // An empty Execute slot: nothing enabled, condition "always" so it is harmless.
    localparam ctrl_e_t CTRL_E_BUBBLE = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        pc_src:     1'b0,
        flag_write: 2'b00,
        cond:       COND_AL,
        wa3:        4'd0
    };

    localparam ctrl_m_t CTRL_M_BUBBLE = '0;

    // An instruction executes only if the slot is occupied, its check passed and it is not "never".
    function automatic logic cond_ok(input logic [3:0] cond, input logic valid, input logic cond_ex);
        return (cond == COND_NV) ? 1'b0 : (valid & cond_ex);
    endfunction

endpackage

// File: rtl/pipe_flopenrc.sv
// Pipeline register with load enable, synchronous clear and asynchronous active-low reset.
// One cycle: q follows d on the rising edge when enabled; clear wins over enable.
// No handshake; the owner stalls it by dropping en.
module pipe_flopenrc #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset and clear both load RST_VAL so a cleared stage looks exactly like a reset one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= RST_VAL;
        end else if (clr) begin
            r_q <= RST_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_execute_ctrl.sv
// Execute-stage control: D->E capture, condition gating, flags register and E->M hand-off.
// D->E, flags and E->M each one cycle; BranchTakenE is combinational from the E slot.
// StallE holds E and sends a bubble to M; FlushE turns the incoming instruction into a bubble.
module pipe_execute_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       MemtoRegD,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic [1:0] FlagWriteD,
    input  logic [3:0] CondD,
    input  logic [3:0] WA3D,
    input  logic       CondExE,
    input  logic [3:0] NextFlagsE,
    output logic [3:0] CondE,
    output logic [1:0] FlagWriteE,
    output logic [3:0] FlagsE,
    output logic       ValidE,
    output logic       BranchTakenE,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       MemtoRegM,
    output logic       PCSrcM,
    output logic [3:0] WA3M
);

    ctrl_e_t    w_e_d;
    ctrl_e_t    w_e_q;
    ctrl_m_t    w_m_d;
    ctrl_m_t    w_m_q;
    logic [3:0] w_flags_q;
    logic       w_cond_ok;
    logic       w_flags_en;

    // A captured Decode instruction always occupies the slot.
    assign w_e_d = '{
        valid:      1'b1,
        reg_write:  RegWriteD,
        mem_write:  MemWriteD,
        mem_to_reg: MemtoRegD,
        branch:     BranchD,
        pc_src:     PCSrcD,
        flag_write: FlagWriteD,
        cond:       CondD,
        wa3:        WA3D
    };

    // Flush takes priority over stall, so a flushed slot is a bubble even while stalled.
    pipe_flopenrc #(
        .WIDTH   ($bits(ctrl_e_t)),
        .RST_VAL (CTRL_E_BUBBLE)
    ) u_de_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~StallE),
        .clr     (FlushE),
        .d       (w_e_d),
        .q       (w_e_q)
    );

    assign w_cond_ok    = cond_ok(w_e_q.cond, w_e_q.valid, CondExE);
    assign BranchTakenE = w_e_q.branch & w_cond_ok;

    // Flags update at the edge that ends the producer's E cycle, once per instruction.
    assign w_flags_en = w_e_q.valid & ~StallE & (w_e_q.cond != COND_NV);

    pipe_flopenrc #(
        .WIDTH   (4),
        .RST_VAL (4'b0000)
    ) u_flags_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_flags_en),
        .clr     (1'b0),
        .d       (NextFlagsE),
        .q       (w_flags_q)
    );

    // Side-effecting controls are gated; MemtoReg and the destination pass through untouched.
    assign w_m_d = '{
        reg_write:  w_e_q.reg_write & w_cond_ok,
        mem_write:  w_e_q.mem_write & w_cond_ok,
        mem_to_reg: w_e_q.mem_to_reg,
        pc_src:     w_e_q.pc_src & w_cond_ok,
        wa3:        w_e_q.wa3
    };

    // Stalled cycles hand M a bubble so the held instruction reaches M exactly once.
    pipe_flopenrc #(
        .WIDTH   ($bits(ctrl_m_t)),
        .RST_VAL (CTRL_M_BUBBLE)
    ) u_em_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .clr     (StallE),
        .d       (w_m_d),
        .q       (w_m_q)
    );

    assign CondE      = w_e_q.cond;
    assign FlagWriteE = w_e_q.flag_write;
    assign ValidE     = w_e_q.valid;
    assign FlagsE     = w_flags_q;
    assign RegWriteM  = w_m_q.reg_write;
    assign MemWriteM  = w_m_q.mem_write;
    assign MemtoRegM  = w_m_q.mem_to_reg;
    assign PCSrcM     = w_m_q.pc_src;
    assign WA3M       = w_m_q.wa3;

endmodule

// File: tb/tb_pipe_execute_ctrl.sv
// Bench for pipe_execute_ctrl: directed instruction scenarios followed by random traffic.
// Expected outputs come from an instruction-level model and are queued per cycle.
// A separate monitor pops the queue and compares against the DUT mid-cycle.
module tb_pipe_execute_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       StallE, FlushE;
    logic       RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD;
    logic [1:0] FlagWriteD;
    logic [3:0] CondD, WA3D;
    logic       CondExE;
    logic [3:0] NextFlagsE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] FlagsE;
    logic       ValidE, BranchTakenE;
    logic       RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [3:0] WA3M;

    always #5 clk = ~clk;

    pipe_execute_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .RegWriteD    (RegWriteD),
        .MemWriteD    (MemWriteD),
        .MemtoRegD    (MemtoRegD),
        .BranchD      (BranchD),
        .PCSrcD       (PCSrcD),
        .FlagWriteD   (FlagWriteD),
        .CondD        (CondD),
        .WA3D         (WA3D),
        .CondExE      (CondExE),
        .NextFlagsE   (NextFlagsE),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .FlagsE       (FlagsE),
        .ValidE       (ValidE),
        .BranchTakenE (BranchTakenE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .PCSrcM       (PCSrcM),
        .WA3M         (WA3M)
    );

    // One instruction as the model sees it.
    typedef struct {
        bit       valid, rw, mw, m2r, br, pcs;
        bit [1:0] fw;
        bit [3:0] cond, wa3;
    } instr_t;

    // What reached the Memory stage.
    typedef struct {
        bit       rw, mw, m2r, pcs;
        bit [3:0] wa3;
    } mem_t;

    // All observable outputs for one cycle.
    typedef struct {
        bit [3:0] cond;
        bit [1:0] fw;
        bit [3:0] flags;
        bit       valid, taken, rw, mw, m2r, pcs;
        bit [3:0] wa3;
    } exp_t;

    exp_t     sb[$];
    instr_t   m_e;
    mem_t     m_m;
    bit [3:0] m_flags;
    int       checks = 0;
    int       errors = 0;

    function automatic instr_t bubble();
        instr_t b = '{default: 0};
        b.cond = 4'b1110;
        return b;
    endfunction

    function automatic instr_t mk(input bit rw, input bit mw, input bit m2r, input bit br,
                                  input bit pcs, input bit [1:0] fw, input bit [3:0] cond,
                                  input bit [3:0] wa3);
        instr_t i;
        i.valid = 1'b1; i.rw = rw; i.mw = mw; i.m2r = m2r; i.br = br; i.pcs = pcs;
        i.fw = fw; i.cond = cond; i.wa3 = wa3;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 0, 2'b00, 4'b1110, 4'd0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs after the falling edge, queue the outputs the model predicts
    // for this cycle, then advance the model to what the next rising edge should produce.
    task automatic drive(input bit rst, input bit stall, input bit flush, input bit condex,
                         input bit [3:0] nf, input instr_t d);
        exp_t   x;
        mem_t   nm;
        bit     executes;
        @(negedge clk);
        reset_n    = !rst;
        StallE     = stall;
        FlushE     = flush;
        RegWriteD  = d.rw;
        MemWriteD  = d.mw;
        MemtoRegD  = d.m2r;
        BranchD    = d.br;
        PCSrcD     = d.pcs;
        FlagWriteD = d.fw;
        CondD      = d.cond;
        WA3D       = d.wa3;
        CondExE    = condex;
        NextFlagsE = nf;
        if (rst) begin
            m_e     = bubble();
            m_m     = '{default: 0};
            m_flags = 4'b0000;
        end
        executes = m_e.valid && (m_e.cond != 4'b1111) && condex;
        x.cond  = m_e.cond;
        x.fw    = m_e.fw;
        x.flags = m_flags;
        x.valid = m_e.valid;
        x.taken = m_e.br && executes;
        x.rw    = m_m.rw;
        x.mw    = m_m.mw;
        x.m2r   = m_m.m2r;
        x.pcs   = m_m.pcs;
        x.wa3   = m_m.wa3;
        sb.push_back(x);
        if (!rst) begin
            if (stall) begin
                nm = '{default: 0};
            end else begin
                nm.rw  = m_e.rw && executes;
                nm.mw  = m_e.mw && executes;
                nm.m2r = m_e.m2r;
                nm.pcs = m_e.pcs && executes;
                nm.wa3 = m_e.wa3;
            end
            if (m_e.valid && !stall && m_e.cond != 4'b1111) m_flags = nf;
            if (flush)       m_e = bubble();
            else if (!stall) m_e = d;
            m_m = nm;
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("CondE",        CondE,        e.cond);
                chk("FlagWriteE",   FlagWriteE,   e.fw);
                chk("FlagsE",       FlagsE,       e.flags);
                chk("ValidE",       ValidE,       e.valid);
                chk("BranchTakenE", BranchTakenE, e.taken);
                chk("RegWriteM",    RegWriteM,    e.rw);
                chk("MemWriteM",    MemWriteM,    e.mw);
                chk("MemtoRegM",    MemtoRegM,    e.m2r);
                chk("PCSrcM",       PCSrcM,       e.pcs);
                chk("WA3M",         WA3M,         e.wa3);
            end
        end
    end

    initial begin
        instr_t d;
        reset_n = 1'b0;
        StallE = 0; FlushE = 0; RegWriteD = 0; MemWriteD = 0; MemtoRegD = 0;
        BranchD = 0; PCSrcD = 0; FlagWriteD = 0; CondD = 0; WA3D = 0;
        CondExE = 0; NextFlagsE = 0;
        m_e = bubble(); m_m = '{default: 0}; m_flags = 0;

        // Reset state, then release; first capture on the following rising edge.
        drive(1, 0, 0, 0, 4'h0, mk(1, 1, 1, 1, 1, 2'b11, 4'h3, 4'h9));
        drive(1, 0, 0, 1, 4'hf, mk(1, 1, 1, 1, 1, 2'b11, 4'h3, 4'h9));

        // ADDS then a second flag-setter back to back, then a consumer.
        drive(0, 0, 0, 1, 4'h0, mk(1, 0, 0, 0, 0, 2'b11, 4'b1110, 4'd3));
        drive(0, 0, 0, 1, 4'b0100, mk(1, 0, 0, 0, 0, 2'b11, 4'b1110, 4'd4));
        drive(0, 0, 0, 1, 4'b1001, nop());
        drive(0, 0, 0, 1, 4'b0000, nop());

        // BEQ not taken, then BEQ taken.
        drive(0, 0, 0, 0, 4'h0, mk(0, 0, 0, 1, 1, 2'b00, 4'b0000, 4'd15));
        drive(0, 0, 0, 0, 4'h0, mk(0, 0, 0, 1, 1, 2'b00, 4'b0000, 4'd15));
        drive(0, 0, 0, 1, 4'h0, nop());
        drive(0, 0, 0, 1, 4'h0, nop());

        // STR held for two stalled cycles; flags must not move while stalled.
        drive(0, 0, 0, 1, 4'h0, mk(0, 1, 0, 0, 0, 2'b00, 4'b1110, 4'd5));
        drive(0, 1, 0, 1, 4'b0110, nop());
        drive(0, 1, 0, 1, 4'b0111, nop());
        drive(0, 0, 0, 1, 4'b0010, nop());
        drive(0, 0, 0, 1, 4'b0010, nop());

        // Flush a register write, and flush together with stall.
        drive(0, 0, 1, 1, 4'h0, mk(1, 0, 0, 0, 0, 2'b11, 4'b1110, 4'd7));
        drive(0, 0, 0, 1, 4'b1100, mk(1, 1, 1, 1, 1, 2'b11, 4'b1110, 4'd8));
        drive(0, 1, 1, 1, 4'b0101, nop());
        drive(0, 0, 0, 1, 4'b0101, nop());

        // Reserved condition never executes even with the check reporting true.
        drive(0, 0, 0, 1, 4'h0, mk(1, 1, 0, 1, 1, 2'b11, 4'b1111, 4'd6));
        drive(0, 0, 0, 1, 4'b1111, nop());
        drive(0, 0, 0, 1, 4'b1111, nop());

        // Build FlagsE=1010 with work in flight, then reset mid-stream.
        drive(0, 0, 0, 1, 4'h0, mk(1, 0, 0, 0, 0, 2'b11, 4'b1110, 4'd2));
        drive(0, 0, 0, 1, 4'b1010, mk(1, 1, 1, 1, 1, 2'b00, 4'b1110, 4'd9));
        drive(0, 0, 0, 1, 4'b0001, mk(1, 1, 1, 1, 1, 2'b00, 4'b1110, 4'd9));
        drive(1, 0, 0, 1, 4'b0001, mk(1, 1, 1, 1, 1, 2'b00, 4'b1110, 4'd9));
        drive(0, 0, 0, 1, 4'b0001, mk(1, 0, 1, 0, 0, 2'b01, 4'b1110, 4'd11));
        drive(0, 0, 0, 1, 4'b0011, nop());

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            d = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), d);
        end

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
